// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
// Build option: RF_ARB_STARVE_GUARD_EN enables the forced-drain starvation guard.
package rf_arb_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int ADDR_WIDTH_DEF   = 5;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] data;
    } ll_entry_t;

    typedef enum logic {
        OWN_PIPE,
        OWN_LL
    } owner_e;

endpackage

// File: rtl/rf_arb_fifo.sv
// First-word-fall-through FIFO holding long-latency results until a write-port slot opens.
// Build option: none (RF_ARB_STARVE_GUARD_EN is consumed by rf_write_arbiter).
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = ll_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_do, pop_do;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_do = push && !full;
    assign pop_do  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_do) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_do)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_do, pop_do})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after the count says it was written.
    always_ff @(posedge clk) begin
        if (push_do) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered long-latency results.
// Build option: RF_ARB_STARVE_GUARD_EN adds the starvation counter and stall_req forced drain.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int PEND_DEPTH   = 2,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [ADDR_WIDTH-1:0]    wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     ll_valid,
    input  logic [ADDR_WIDTH-1:0]    ll_rd,
    input  logic [DATA_WIDTH-1:0]    ll_data,
    output logic                     ll_ready,
    input  logic                     iss_valid,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    output logic                     iss_ready,
    input  logic [ADDR_WIDTH-1:0]    rs1,
    input  logic [ADDR_WIDTH-1:0]    rs2,
    input  logic [ADDR_WIDTH-1:0]    rd,
    output logic                     hazard,
    output logic [2**ADDR_WIDTH-1:0] busy_vec,
    output logic                     stall_req,
    output logic                     rf_we,
    output logic [ADDR_WIDTH-1:0]    rf_ad,
    output logic [DATA_WIDTH-1:0]    rf_wd
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam int CW   = $clog2(PEND_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          push_entry, head;
    logic            fifo_full, fifo_empty, push, pop, iss_fire;
    logic [CW-1:0]   fifo_count, in_flight_q, in_flight_d;
    logic [CW:0]     outstanding;
    logic [NREG-1:0] busy_q, busy_d;
    owner_e          owner;

    assign push_entry = '{rd: ll_rd, data: ll_data};

    rf_arb_fifo #(
        .DEPTH (PEND_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outstanding = issued but not yet returned, plus returned but not yet written.
    assign outstanding = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign ll_ready    = !rst && !fifo_full;
    assign iss_ready   = !rst && !busy_q[iss_rd] && (outstanding < (CW+1)'(PEND_DEPTH));
    assign push        = ll_valid && ll_ready;
    assign iss_fire    = iss_valid && iss_ready;

    always_comb begin
        owner = OWN_PIPE;
        if (stall_req || (!fifo_empty && (!wb_we || wb_rd == '0))) owner = OWN_LL;
    end

    assign pop   = !rst && (owner == OWN_LL) && !fifo_empty;
    assign rf_we = !rst && ((owner == OWN_LL) ? (!fifo_empty && head.rd != '0)
                                              : (wb_we && wb_rd != '0));
    assign rf_ad = (owner == OWN_LL) ? head.rd   : wb_rd;
    assign rf_wd = (owner == OWN_LL) ? head.data : wb_data;

    // NOTE: next-state logic uses blocking '=' in always_comb with defaults first; state uses '<='.
    always_comb begin
        busy_d      = busy_q;
        in_flight_d = in_flight_q;
        if (pop) busy_d[head.rd] = 1'b0;
        if (iss_fire && iss_rd != '0) busy_d[iss_rd] = 1'b1;
        if (iss_fire && !(push && in_flight_q != '0)) in_flight_d = in_flight_q + CW'(1);
        else if (!iss_fire && push && in_flight_q != '0) in_flight_d = in_flight_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            in_flight_q <= '0;
        end else begin
            busy_q      <= busy_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign busy_vec = busy_q;
    assign hazard   = (rs1 != '0 && busy_q[rs1]) ||
                      (rs2 != '0 && busy_q[rs2]) ||
                      (rd  != '0 && busy_q[rd]);

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (pop) starve_d = '0;
        else if (!fifo_empty && owner == OWN_PIPE && starve_q != 4'(STARVE_LIMIT))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign stall_req = (starve_q == 4'(STARVE_LIMIT));
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default parameters).
// Build option: RF_ARB_STARVE_GUARD_EN selects the forced-drain scenario.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we, ll_valid, iss_valid;
    logic [4:0]  wb_rd, ll_rd, iss_rd, rs1, rs2, rd;
    logic [31:0] wb_data, ll_data;
    logic        ll_ready, iss_ready, hazard, stall_req, rf_we;
    logic [31:0] busy_vec;
    logic [4:0]  rf_ad;
    logic [31:0] rf_wd;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .ll_valid  (ll_valid),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .ll_ready  (ll_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .hazard    (hazard),
        .busy_vec  (busy_vec),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_ad     (rf_ad),
        .rf_wd     (rf_wd)
    );

    // Inputs change 1 time unit after the rising edge; checks happen 4 units later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0;
        iss_valid = 0; iss_rd = 0;
        rs1 = 0; rs2 = 0; rd = 0;
    endtask

    task automatic test_reset;
        rst = 1; idle();
        tick(); tick();
        #4;
        n_run++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
        n_run++; if (ll_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ll_ready got=%0b exp=0", ll_ready); end
        n_run++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iss_ready got=%0b exp=0", iss_ready); end
        n_run++; if (hazard !== 1'b0)    begin n_fail++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
        n_run++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
        rst = 0;
        tick();
    endtask

    task automatic test_pipe_pass;
        idle();
        wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #4;
        n_run++; if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL pipe_pass got we=%0b ad=%0d wd=%h exp we=1 ad=5 wd=deadbeef", rf_we, rf_ad, rf_wd); end
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL pipe_busy got=%h exp=0", busy_vec); end
        n_run++; if ({ll_ready, iss_ready} !== 2'b11)
            begin n_fail++; $display("FAIL pipe_ready got=%b exp=11", {ll_ready, iss_ready}); end
        tick();
    endtask

    task automatic test_scoreboard;
        idle();
        iss_valid = 1; iss_rd = 7;
        #4;
        n_run++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sb_iss_ready got=%0b exp=1", iss_ready); end
        tick();
        idle();
        rs1 = 7; ll_valid = 1; ll_rd = 7; ll_data = 32'h12;
        #4;
        n_run++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_set got=%0b exp=1", hazard); end
        n_run++; if (busy_vec !== 32'h80) begin n_fail++; $display("FAIL sb_busy_set got=%h exp=00000080", busy_vec); end
        n_run++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass got=%0b exp=0", rf_we); end
        tick();
        ll_valid = 0;
        #4;
        n_run++; if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd7, 32'h12})
            begin n_fail++; $display("FAIL sb_ll_write got we=%0b ad=%0d wd=%h exp we=1 ad=7 wd=12", rf_we, rf_ad, rf_wd); end
        n_run++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_hold got=%0b exp=1", hazard); end
        tick();
        #4;
        n_run++; if ({hazard, busy_vec} !== {1'b0, 32'h0})
            begin n_fail++; $display("FAIL sb_clear got hazard=%0b busy=%h exp hazard=0 busy=0", hazard, busy_vec); end
        tick();
    endtask

    task automatic test_fill;
        idle();
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_rd = 4;
        tick();
        iss_rd = 9;
        wb_we = 1; wb_rd = 10; wb_data = 32'h1;
        ll_valid = 1; ll_rd = 3; ll_data = 32'h33;
        #4;
        n_run++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL fill_iss_limit got=%0b exp=0", iss_ready); end
        n_run++; if (rf_ad !== 5'd10) begin n_fail++; $display("FAIL fill_pipe_owns got=%0d exp=10", rf_ad); end
        tick();
        iss_valid = 0;
        wb_rd = 11; ll_rd = 4; ll_data = 32'h44;
        #4;
        n_run++; if ({ll_ready, rf_ad} !== {1'b1, 5'd11})
            begin n_fail++; $display("FAIL fill_second got ready=%0b ad=%0d exp ready=1 ad=11", ll_ready, rf_ad); end
        tick();
        wb_rd = 12; ll_rd = 12; ll_data = 32'hCC;
        #4;
        n_run++; if (ll_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got=%0b exp=0", ll_ready); end
        tick();
        idle();
        #4;
        n_run++; if ({rf_we, rf_ad, rf_wd, ll_ready} !== {1'b1, 5'd3, 32'h33, 1'b0})
            begin n_fail++; $display("FAIL fill_pop3 got we=%0b ad=%0d wd=%h rdy=%0b exp we=1 ad=3 wd=33 rdy=0", rf_we, rf_ad, rf_wd, ll_ready); end
        tick();
        #4;
        n_run++; if ({rf_we, rf_ad, rf_wd, ll_ready} !== {1'b1, 5'd4, 32'h44, 1'b1})
            begin n_fail++; $display("FAIL fill_pop4 got we=%0b ad=%0d wd=%h rdy=%0b exp we=1 ad=4 wd=44 rdy=1", rf_we, rf_ad, rf_wd, ll_ready); end
        tick();
        #4;
        n_run++; if ({rf_we, busy_vec} !== {1'b0, 32'h0})
            begin n_fail++; $display("FAIL fill_drained got we=%0b busy=%h exp we=0 busy=0", rf_we, busy_vec); end
        tick();
    endtask

    task automatic test_starve;
        idle();
        iss_valid = 1; iss_rd = 6;
        tick();
        iss_valid = 0;
        ll_valid = 1; ll_rd = 6; ll_data = 32'h66;
        wb_we = 1; wb_rd = 1; wb_data = 32'h100;
        tick();
        ll_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'(13 + i); wb_data = 32'(i);
            #4;
            n_run++; if ({stall_req, rf_ad} !== {1'b0, 5'(13 + i)})
                begin n_fail++; $display("FAIL starve_blocked%0d got stall=%0b ad=%0d exp stall=0 ad=%0d", i, stall_req, rf_ad, 13 + i); end
            tick();
        end
        wb_rd = 20; wb_data = 32'hAA;
`ifdef RF_ARB_STARVE_GUARD_EN
        #4;
        n_run++; if ({stall_req, rf_we, rf_ad, rf_wd} !== {1'b1, 1'b1, 5'd6, 32'h66})
            begin n_fail++; $display("FAIL starve_force got stall=%0b we=%0b ad=%0d wd=%h exp stall=1 we=1 ad=6 wd=66", stall_req, rf_we, rf_ad, rf_wd); end
        tick();
        #4;
        n_run++; if ({stall_req, rf_we, rf_ad, rf_wd} !== {1'b0, 1'b1, 5'd20, 32'hAA})
            begin n_fail++; $display("FAIL starve_held_wb got stall=%0b we=%0b ad=%0d wd=%h exp stall=0 we=1 ad=20 wd=aa", stall_req, rf_we, rf_ad, rf_wd); end
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL starve_busy got=%h exp=0", busy_vec); end
        tick();
`else
        #4;
        n_run++; if ({stall_req, rf_ad} !== {1'b0, 5'd20})
            begin n_fail++; $display("FAIL noguard_no_stall got stall=%0b ad=%0d exp stall=0 ad=20", stall_req, rf_ad); end
        tick();
        wb_we = 0;
        #4;
        n_run++; if ({rf_we, rf_ad, rf_wd} !== {1'b1, 5'd6, 32'h66})
            begin n_fail++; $display("FAIL noguard_idle_drain got we=%0b ad=%0d wd=%h exp we=1 ad=6 wd=66", rf_we, rf_ad, rf_wd); end
        tick();
        #4;
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL noguard_busy got=%h exp=0", busy_vec); end
        tick();
`endif
    endtask

    task automatic test_x0;
        idle();
        iss_valid = 1; iss_rd = 0;
        wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF;
        #4;
        n_run++; if ({iss_ready, rf_we} !== 2'b10)
            begin n_fail++; $display("FAIL x0_issue_wb got iss_ready=%0b we=%0b exp 1 0", iss_ready, rf_we); end
        tick();
        idle();
        ll_valid = 1; ll_rd = 0; ll_data = 32'h5;
        #4;
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_no_busy got=%h exp=0", busy_vec); end
        tick();
        ll_valid = 0;
        #4;
        n_run++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_pop_dropped got=%0b exp=0", rf_we); end
        tick();
        iss_valid = 1; iss_rd = 8;
        #4;
        n_run++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_outstanding_freed got=%0b exp=1", iss_ready); end
        tick();
        #4;
        n_run++; if ({iss_ready, busy_vec} !== {1'b0, 32'h100})
            begin n_fail++; $display("FAIL busy_reissue got ready=%0b busy=%h exp ready=0 busy=00000100", iss_ready, busy_vec); end
        tick();
    endtask

    task automatic test_reset_mid;
        idle();
        iss_valid = 1; iss_rd = 2;
        tick();
        iss_valid = 0;
        ll_valid = 1; ll_rd = 8; ll_data = 32'h88;
        wb_we = 1; wb_rd = 1; wb_data = 32'h1;
        tick();
        ll_rd = 2; ll_data = 32'h22;
        tick();
        idle();
        rs1 = 8; rs2 = 2;
        #4;
        n_run++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL mid_pre_hazard got=%0b exp=1", hazard); end
        rst = 1;
        tick();
        iss_rd = 8;
        #4;
        n_run++; if ({rf_we, ll_ready, iss_ready, hazard, stall_req} !== 5'b0)
            begin n_fail++; $display("FAIL mid_reset_outs got we,llr,issr,haz,stall=%b exp=00000", {rf_we, ll_ready, iss_ready, hazard, stall_req}); end
        n_run++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL mid_reset_busy got=%h exp=0", busy_vec); end
        rst = 0;
        tick();
        #4;
        n_run++; if ({rf_we, ll_ready, iss_ready} !== 3'b011)
            begin n_fail++; $display("FAIL mid_release got we,llr,issr=%b exp=011", {rf_we, ll_ready, iss_ready}); end
        tick();
        #4;
        n_run++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got=%0b exp=0", rf_we); end
        tick();
    endtask

    initial begin
        test_reset();
        test_pipe_pass();
        test_scoreboard();
        test_fill();
        test_starve();
        test_x0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (AD3/WD3/WE3) between the in-order pipeline writeback and a long-latency result source such as a multiply/divide unit or a load return. It buffers long-latency results in a small FIFO and drains them into write-port idle cycles. A destination-register scoreboard supplies decode with a RAW/WAW hazard flag. An optional starvation guard forces a drain by requesting a one-cycle pipeline freeze.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers; x0 hard-wired zero)
- PEND_DEPTH, 2, long-latency result FIFO depth (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before a forced drain (1..15)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  pipeline writeback enable
- wb_rd  in  ADDR_WIDTH  pipeline destination
- wb_data  in  DATA_WIDTH  pipeline write data
- ll_valid  in  1  long-latency result valid
- ll_rd  in  ADDR_WIDTH  long-latency destination
- ll_data  in  DATA_WIDTH  long-latency data
- ll_ready  out  1  FIFO can accept a result
- iss_valid  in  1  long-latency op issuing
- iss_rd  in  ADDR_WIDTH  its destination
- iss_ready  out  1  issue accepted this cycle
- rs1, rs2, rd  in  ADDR_WIDTH  decode-stage operand and destination addresses
- hazard  out  1  decode must stall
- busy_vec  out  2**ADDR_WIDTH  scoreboard bits
- stall_req  out  1  pipeline freeze request (starvation guard)
- rf_we  out  1  to reg file WE3
- rf_ad  out  ADDR_WIDTH  to AD3
- rf_wd  out  DATA_WIDTH  to WD3

## Operation
- Write-port owner each cycle:
  - FIFO head if stall_req=1, or if the FIFO is non-empty and (wb_we=0 or wb_rd=0).
  - Otherwise the pipeline.
- Pipeline writes are never backpressured except while stall_req=1. During that cycle wb_* is ignored, and the pipeline holds wb_* for the next cycle.
- Writes to x0 are dropped (rf_we=0). x0 results are still popped from the FIFO.
- FIFO push: ll_valid & ll_ready. ll_ready = FIFO not full; it is registered-state derived, so a pop does not create same-cycle space.
- Scoreboard:
  - busy[iss_rd] is set on iss_valid & iss_ready, unless iss_rd=0.
  - busy[ll_rd] is cleared when that entry is written (popped) to the register file.
- iss_ready = !busy[iss_rd] & (outstanding count < PEND_DEPTH), using registered state. Only one outstanding write per register.
- hazard = busy[rs1]|busy[rs2]|busy[rd], with x0 operands excluded. It is combinational from registered busy_vec.
- A pipeline write to a busy register is a protocol error, prevented by hazard; no correction is made.
- Set and clear of the same register cannot coincide, because issue requires busy=0.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the pipeline owns the port.
  - Resets on any pop.
  - Saturates at STARVE_LIMIT.
- stall_req = (counter == STARVE_LIMIT).

## Timing
- Pipeline writeback: 0-cycle, combinational pass-through to rf_*.
- Long-latency result: pushed at edge N; earliest register-file write is cycle N+1.
- FIFO FWFT; no same-cycle push-to-write bypass.
- Scoreboard set/clear is visible on hazard the cycle after the edge.
- Forced drain happens STARVE_LIMIT cycles after the first blocked cycle; stall_req is high for exactly one cycle per forced pop.
- Reset values: rf_we=0, ll_ready=0, iss_ready=0, hazard=0, stall_req=0, busy_vec=0, FIFO empty, counter 0. Reset mid-operation discards all pending results and busy bits.
- Simultaneous push and pop while full: push refused (ll_ready=0); pop proceeds.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined: starvation counter and stall_req are implemented as above.
- Not defined: no counter; stall_req tied 0. The FIFO drains only in pipeline-idle cycles, and software/pipeline guarantees idle slots.

## Structure
- rf_arb_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults
  - STARVE_LIMIT default
  - ll_entry_t struct {rd, data}
  - owner enum {OWN_PIPE, OWN_LL}
- Sub-module rf_arb_fifo: parameterised FWFT FIFO of ll_entry_t with full/empty/count.
- The scoreboard and arbitration live in rf_write_arbiter.

## Test plan
- Reset, then wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle rf_we=1, rf_ad=5, rf_wd=0xDEADBEEF; busy_vec=0.
- Issue iss_rd=7; next cycle rs1=7 -> hazard=1. ll result rd=7 data=0x12 with wb_we=0 -> written the following cycle; busy[7]=0 and hazard=0 one cycle later.
- Issue rd 3 and rd 4, return both while wb_we=1 for 2 cycles -> ll_ready=0 with 2 entries; third ll_valid held off. wb idle -> pops in order 3 then 4.
- With the guard defined, STARVE_LIMIT=4, continuous wb_we=1 and one pending entry -> stall_req=1 on the 5th cycle. That cycle writes the FIFO entry; the held wb write lands next cycle.
- iss_rd=0 and wb_rd=0 -> no busy bit, rf_we=0. Issue to an already busy rd -> iss_ready=0.
- Assert rst with 2 entries pending and busy bits set -> all outputs at reset values next cycle; no stale write after release.
